// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite memory responder: bus widths, response codes,
// write/read FSM state encodings and the out-of-range address helper.
package axi_lite_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [1:0]        resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_GOT_ADDR, W_GOT_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;

  function automatic logic addr_oob(input addr_t a, input int unsigned depth);
    return a >= addr_t'(4 * depth);
  endfunction
endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bus bundle (AW/W/B/AR/R channels) with slave and master views.
interface axi_lite_if;
  import axi_lite_pkg::*;

  logic  awvalid;
  logic  awready;
  addr_t awaddr;
  logic  wvalid;
  logic  wready;
  data_t wdata;
  logic  bvalid;
  logic  bready;
  resp_t bresp;
  logic  arvalid;
  logic  arready;
  addr_t araddr;
  logic  rvalid;
  logic  rready;
  data_t rdata;
  resp_t rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_rd_channel.sv
// Read path: AR accept, RD_WAIT-cycle delay, registered rdata/rresp held until rready.
// AXI_LITE_SLVERR_EN: out-of-range addresses return SLVERR with rdata=0.
module axi_lite_rd_channel
  import axi_lite_pkg::*;
#(
  parameter  int MEM_DEPTH = 16,
  parameter  int RD_WAIT   = 1,
  localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             aclk,
  input  logic             areset_n,
  input  logic             en,
  input  logic             arvalid,
  input  addr_t            araddr,
  output logic             arready,
  output logic             rvalid,
  input  logic             rready,
  output data_t            rdata,
  output resp_t            rresp,
  output logic [IDX_W-1:0] rd_idx,
  input  data_t            rd_word,
  output logic             busy
);
  rd_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  addr_t      addr_q, addr_c;
  logic       load, sample, oob;
  logic       unused_addr;

  // With RD_WAIT=0 the sample happens on the AR edge itself, before addr_q is loaded.
  assign addr_c      = (state_q == R_IDLE) ? araddr : addr_q;
  assign rd_idx      = addr_c[2 +: IDX_W];
  assign unused_addr = ^addr_c;
`ifdef AXI_LITE_SLVERR_EN
  assign oob = addr_oob(addr_c, MEM_DEPTH);
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    arready = 1'b0;
    rvalid  = 1'b0;
    load    = 1'b0;
    sample  = 1'b0;
    case (state_q)
      R_IDLE: begin
        arready = en;
        if (arvalid && en) begin
          load = 1'b1;
          if (RD_WAIT == 0) begin
            state_d = R_DATA;
            sample  = 1'b1;
          end else begin
            state_d = R_WAIT;
            cnt_d   = 3'(RD_WAIT);
          end
        end
      end
      R_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = R_DATA;
          sample  = 1'b1;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign busy = (state_q != R_IDLE);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= R_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) addr_q <= araddr;
      if (sample) begin
        rdata <= oob ? '0 : rd_word;
        rresp <= oob ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end
endmodule

// File: rtl/axi_lite_mem_responder.sv
// AXI-Lite slave backed by a MEM_DEPTH x 32-bit register memory; independent write/read FSMs.
// AXI_LITE_SLVERR_EN: out-of-range addresses answer SLVERR instead of wrapping.
module axi_lite_mem_responder
  import axi_lite_pkg::*;
#(
  parameter int MEM_DEPTH = 16,
  parameter int RD_WAIT   = 1
) (
  input  logic        aclk,
  input  logic        areset_n,
  axi_lite_if.slave   s_axi_lite,
  output logic        busy
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  wr_state_e        wr_q, wr_d;
  logic             en_q;
  addr_t            awaddr_q, waddr_c;
  data_t            wdata_q, wdata_c;
  logic             awready_c, wready_c, aw_hs, w_hs, commit, w_oob;
  logic             bvalid_q;
  resp_t            bresp_q;
  data_t            mem [MEM_DEPTH];
  logic [IDX_W-1:0] widx, rd_idx;
  logic             rd_busy;
  logic             unused_waddr;

  always_comb begin
    wr_d      = wr_q;
    awready_c = 1'b0;
    wready_c  = 1'b0;
    case (wr_q)
      W_IDLE:     begin awready_c = en_q; wready_c = en_q; end
      W_GOT_ADDR: wready_c  = 1'b1;
      W_GOT_DATA: awready_c = 1'b1;
      default:    ;
    endcase
    aw_hs = s_axi_lite.awvalid && awready_c;
    w_hs  = s_axi_lite.wvalid && wready_c;
    case (wr_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_d = W_RESP;
        else if (aw_hs)    wr_d = W_GOT_ADDR;
        else if (w_hs)     wr_d = W_GOT_DATA;
      end
      W_GOT_ADDR: if (w_hs)  wr_d = W_RESP;
      W_GOT_DATA: if (aw_hs) wr_d = W_RESP;
      W_RESP:     if (bvalid_q && s_axi_lite.bready) wr_d = W_IDLE;
      default:    wr_d = W_IDLE;
    endcase
  end

  // The commit edge takes whichever half arrives on that edge straight from the bus.
  assign commit       = (wr_d == W_RESP) && (wr_q != W_RESP);
  assign waddr_c      = (wr_q == W_GOT_ADDR) ? awaddr_q : s_axi_lite.awaddr;
  assign wdata_c      = (wr_q == W_GOT_DATA) ? wdata_q : s_axi_lite.wdata;
  assign widx         = waddr_c[2 +: IDX_W];
  assign unused_waddr = ^waddr_c;
`ifdef AXI_LITE_SLVERR_EN
  assign w_oob = addr_oob(waddr_c, MEM_DEPTH);
`else
  assign w_oob = 1'b0;
`endif

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_q     <= W_IDLE;
      en_q     <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      awaddr_q <= '0;
      wdata_q  <= '0;
    end else begin
      wr_q     <= wr_d;
      en_q     <= 1'b1;
      bvalid_q <= (wr_q == W_RESP) && !(bvalid_q && s_axi_lite.bready);
      if (aw_hs)  awaddr_q <= s_axi_lite.awaddr;
      if (w_hs)   wdata_q  <= s_axi_lite.wdata;
      if (commit) bresp_q  <= w_oob ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (commit && !w_oob) begin
      mem[widx] <= wdata_c;
    end
  end

  assign s_axi_lite.awready = awready_c;
  assign s_axi_lite.wready  = wready_c;
  assign s_axi_lite.bvalid  = bvalid_q;
  assign s_axi_lite.bresp   = bresp_q;
  assign busy               = (wr_q != W_IDLE) || rd_busy;

  axi_lite_rd_channel #(
    .MEM_DEPTH(MEM_DEPTH),
    .RD_WAIT  (RD_WAIT)
  ) u_rd (
    .aclk    (aclk),
    .areset_n(areset_n),
    .en      (en_q),
    .arvalid (s_axi_lite.arvalid),
    .araddr  (s_axi_lite.araddr),
    .arready (s_axi_lite.arready),
    .rvalid  (s_axi_lite.rvalid),
    .rready  (s_axi_lite.rready),
    .rdata   (s_axi_lite.rdata),
    .rresp   (s_axi_lite.rresp),
    .rd_idx  (rd_idx),
    .rd_word (mem[rd_idx]),
    .busy    (rd_busy)
  );
endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Bench for axi_lite_mem_responder: directed scenarios plus random single transactions
// against an array memory model.
module tb_axi_lite_mem_responder;
  import axi_lite_pkg::*;

  localparam int MEM_DEPTH = 16;
  localparam int RD_WAIT   = 3;

  logic aclk     = 1'b0;
  logic areset_n = 1'b1;
  logic busy;

  axi_lite_if bus();

  axi_lite_mem_responder #(.MEM_DEPTH(MEM_DEPTH), .RD_WAIT(RD_WAIT)) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .s_axi_lite(bus),
    .busy      (busy)
  );

  always #5 aclk = ~aclk;

  int    n_chk = 0;
  int    n_err = 0;
  data_t mem_m [MEM_DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_oob(input addr_t a);
`ifdef AXI_LITE_SLVERR_EN
    return a >= addr_t'(4 * MEM_DEPTH);
`else
    return a != a;
`endif
  endfunction

  function automatic int m_idx(input addr_t a);
    return int'((a / 4) % MEM_DEPTH);
  endfunction

  function automatic void m_write(input addr_t a, input data_t d, output resp_t r);
    if (m_oob(a)) r = RESP_SLVERR;
    else begin
      mem_m[m_idx(a)] = d;
      r = RESP_OKAY;
    end
  endfunction

  function automatic void m_read(input addr_t a, output data_t d, output resp_t r);
    d = m_oob(a) ? 32'd0 : mem_m[m_idx(a)];
    r = m_oob(a) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  task automatic do_write(input addr_t a, input data_t d, input int aw_dly, input int w_dly);
    bit    aw_done, w_done;
    int    cyc, lat;
    resp_t er;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0; lat = -1;
    m_write(a, d, er);
    while (!(aw_done && w_done) && cyc < 20) begin
      @(negedge aclk);
      if (aw_done) chk("got_addr_rdy", 32'({bus.awready, bus.wready}), 32'd1);
      if (w_done)  chk("got_data_rdy", 32'({bus.awready, bus.wready}), 32'd2);
      bus.awvalid = !aw_done && cyc >= aw_dly;
      bus.awaddr  = a;
      bus.wvalid  = !w_done && cyc >= w_dly;
      bus.wdata   = d;
      if (bus.awvalid && bus.awready) aw_done = 1'b1;
      if (bus.wvalid && bus.wready)   w_done  = 1'b1;
      cyc++;
    end
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge aclk);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      if (bus.bvalid) lat = i;
    end
    chk("b_lat", lat, 32'd2);
    chk("b_resp", 32'(bus.bresp), 32'(er));
    @(negedge aclk);
    chk("b_done", 32'({bus.bvalid, busy}), 32'd0);
  endtask

  task automatic do_read(input addr_t a, input int hold);
    int    lat;
    data_t d0, ed;
    resp_t er;
    m_read(a, ed, er);
    lat = -1;
    @(negedge aclk);
    bus.arvalid = 1'b1;
    bus.araddr  = a;
    bus.rready  = 1'b0;
    chk("ar_rdy", 32'(bus.arready), 32'd1);
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge aclk);
      bus.arvalid = 1'b0;
      if (bus.rvalid) lat = i;
    end
    chk("r_lat", lat, RD_WAIT + 1);
    d0 = bus.rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      chk("r_stable", bus.rdata, d0);
      chk("r_hold", 32'(bus.rvalid), 32'd1);
    end
    chk("r_data", bus.rdata, ed);
    chk("r_resp", 32'(bus.rresp), 32'(er));
    bus.rready = 1'b1;
    @(negedge aclk);
    chk("r_done", 32'({bus.rvalid, busy}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    data_t ed;
    resp_t er;
    addr_t a;
    bus.awvalid = 1'b0; bus.awaddr = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0;
    bus.arvalid = 1'b0; bus.araddr = '0;
    bus.bready  = 1'b1; bus.rready = 1'b1;
    foreach (mem_m[i]) mem_m[i] = '0;

    // reset state and ready release
    #2 areset_n = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_rdy", 32'({bus.awready, bus.wready, bus.arready}), 32'd0);
    chk("rst_vld", 32'({bus.bvalid, bus.rvalid, busy}), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_resp", 32'({bus.bresp, bus.rresp}), 32'd0);
    areset_n = 1'b1;
    #1 chk("rel_rdy", 32'({bus.awready, bus.wready, bus.arready}), 32'd0);
    @(negedge aclk);
    chk("post_rdy", 32'({bus.awready, bus.wready, bus.arready}), 32'd7);

    // aligned AW+W, then read back
    do_write(32'h8, 32'hDEAD_BEEF, 0, 0);
    do_read(32'h8, 0);
    // W three cycles ahead of AW
    do_write(32'h4, 32'h1234_5678, 3, 0);
    do_read(32'h4, 0);
    // AW ahead of W
    do_write(32'h1C, 32'h0BAD_F00D, 0, 2);
    do_read(32'h1F, 0);
    // rready held low for 5 cycles
    do_read(32'h4, 5);

    // write commit and read sample on the same edge
    do_write(32'hC, 32'h5555_5555, 0, 0);
    m_read(32'hC, ed, er);
    @(negedge aclk);
    bus.arvalid = 1'b1; bus.araddr = 32'hC; bus.rready = 1'b1;
    @(negedge aclk);
    bus.arvalid = 1'b0;
    repeat (RD_WAIT - 1) @(negedge aclk);
    bus.awvalid = 1'b1; bus.awaddr = 32'hC;
    bus.wvalid  = 1'b1; bus.wdata  = 32'hAAAA_AAAA;
    @(negedge aclk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("same_edge_rvalid", 32'(bus.rvalid), 32'd1);
    chk("same_edge_rdata", bus.rdata, ed);
    m_write(32'hC, 32'hAAAA_AAAA, er);
    repeat (3) @(negedge aclk);
    do_read(32'hC, 0);

    // just beyond the backing store
    do_write(32'h40, 32'hCAFE_F00D, 1, 0);
    do_read(32'h40, 0);
    do_read(32'h0, 0);

    // reset while holding only the write address
    @(negedge aclk);
    bus.awvalid = 1'b1; bus.awaddr = 32'h10;
    @(negedge aclk);
    bus.awvalid = 1'b0;
    chk("got_addr_busy", 32'(busy), 32'd1);
    areset_n = 1'b0;
    #1 chk("async_rst_busy", 32'({busy, bus.awready}), 32'd0);
    @(negedge aclk);
    areset_n = 1'b1;
    foreach (mem_m[i]) mem_m[i] = '0;
    repeat (4) begin
      @(negedge aclk);
      chk("rst_no_b", 32'(bus.bvalid), 32'd0);
    end
    chk("rst_idle", 32'({bus.awready, bus.wready, busy}), 32'd6);
    do_read(32'h10, 0);
    do_read(32'h8, 0);

    // random single transactions, addresses spanning twice the memory
    repeat (60) begin
      a = addr_t'($urandom_range(0, 8 * MEM_DEPTH - 1));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom(), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_lite_mem_responder.md
AXI_LITE_MEM_RESPONDER -- requirements
Module: axi_lite_mem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 16, meaning the number of 32-bit words in the backing store (power of two, 2..256).
REQ-002 SHALL have parameter RD_WAIT, default 1, meaning the wait cycles between AR handshake and RVALID assertion (0..7).
REQ-003 SHALL have port aclk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 SHALL have port areset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port s_axi_lite, axi_lite_if slave side: aw*/w*/b*/ar*/r* channels, addr_t/data_t widths, 2-bit resp.
REQ-006 SHALL have port busy, output, 1 bit: high while any write or read transaction is in progress.

Function
REQ-007 SHALL implement the write FSM with states W_IDLE, W_GOT_ADDR, W_GOT_DATA, W_RESP.
REQ-008 W_IDLE: awready=wready=1; AW-only handshake -> W_GOT_ADDR; W-only handshake -> W_GOT_DATA; both in the same cycle -> W_RESP.
REQ-009 W_GOT_ADDR holds only wready=1 and W_GOT_DATA holds only awready=1; the missing handshake -> W_RESP.
REQ-010 The memory write SHALL commit on the edge entering W_RESP; bvalid=1 from the next cycle until bready, then -> W_IDLE.
REQ-011 Word index SHALL be addr[2 +: log2(MEM_DEPTH)]; addr[1:0] ignored.
REQ-012 SHALL implement the read FSM with states R_IDLE (arready=1), R_WAIT, R_DATA.
REQ-013 AR handshake SHALL latch araddr and go to R_WAIT with the counter at RD_WAIT; it goes straight to R_DATA when RD_WAIT=0.
REQ-014 R_WAIT SHALL decrement the counter and go to R_DATA at zero; rdata is sampled from memory on the edge entering R_DATA.
REQ-015 R_DATA: rvalid=1, rdata/rresp stable until rready, then -> R_IDLE.
REQ-016 Read and write FSMs SHALL run independently and concurrently.
REQ-017 If a write commit and a read sample hit the same word on the same edge, the read SHALL return the pre-write value.
REQ-018 No new AW/W/AR SHALL be accepted while the corresponding response is pending (one outstanding transaction per direction).
REQ-019 busy = (write FSM != W_IDLE) OR (read FSM != R_IDLE).

Reset
REQ-020 areset_n low SHALL immediately force W_IDLE and R_IDLE, with bvalid=rvalid=0, rdata=0, bresp=rresp=2'b00, busy=0, wait counter=0.
REQ-021 awready, wready and arready SHALL be 0 while in reset and 1 from the first edge after release.
REQ-022 Reset mid-transaction SHALL abandon the transaction without a response; a write not yet committed SHALL NOT update memory.
REQ-023 Memory contents SHALL be cleared to 0 on reset.

Configuration
REQ-024 Macro AXI_LITE_SLVERR_EN defined: an address with word index >= MEM_DEPTH (addr >= 4*MEM_DEPTH) SHALL return resp 2'b10 (SLVERR), suppress the memory write, and return rdata=0.
REQ-025 Macro AXI_LITE_SLVERR_EN undefined: addresses SHALL wrap modulo MEM_DEPTH and resp is always 2'b00 (OKAY).

Structure
REQ-026 axi_lite_pkg SHALL hold addr_t, data_t, resp_t, the RESP_OKAY/RESP_SLVERR constants and the write/read FSM state enums.
REQ-027 The read path (R FSM, wait counter, rdata register) SHALL be sub-module axi_lite_rd_channel; the write FSM and memory stay in the top module.

Verification
REQ-028 Write 0x0000_0008 <- 0xDEAD_BEEF with AW and W together, bready=1 -> bvalid 2 cycles after the handshake, bresp=OKAY; a read of 0x8 returns 0xDEAD_BEEF.
REQ-029 W sent 3 cycles before AW (addr 0x4, data 0x1234_5678) -> W_GOT_DATA held, awready stays 1, single B response, memory[1]=0x1234_5678.
REQ-030 RD_WAIT=3, read 0x4 -> rvalid asserts exactly 4 cycles after the AR handshake; with rready=0 for 5 cycles, rdata stays stable.
REQ-031 Same-edge write 0xAAAA_AAAA and read of 0xC (old value 0x5555_5555) -> rdata=0x5555_5555; a subsequent read returns 0xAAAA_AAAA.
REQ-032 With AXI_LITE_SLVERR_EN and MEM_DEPTH=16, write/read of 0x40 -> SLVERR, rdata=0, memory unchanged; without the macro -> OKAY and aliases to word 0.
REQ-033 areset_n pulsed low in W_GOT_ADDR -> bvalid never asserts, memory unchanged, busy=0, awready=wready=1 after release.
